// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter: FSM encoding, write
// length codes and the core's default bus widths.
package mem_arb_pkg;

  localparam int CORE_ADDR_W = 64;
  localparam int CORE_DATA_W = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  localparam logic [1:0] WLEN_BYTE   = 2'd0;
  localparam logic [1:0] WLEN_HALF   = 2'd1;
  localparam logic [1:0] WLEN_WORD   = 2'd2;
  localparam logic [1:0] WLEN_DOUBLE = 2'd3;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel selector: round-robin from a pointer, or fixed
// priority (lowest index wins). The pointer register lives in the parent.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int PRIO_MODE = 0,
  localparam int IDX_W    = idx_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_valid
);

  int cand;

  // Walk the candidates in priority order; the first asserted one wins.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (PRIO_MODE == 1) begin
        cand = i;
      end else begin
        cand = (int'(ptr) + i) % NUM_CH;
      end
      if (!gnt_valid && req[cand]) begin
        gnt_valid  = 1'b1;
        gnt_idx    = IDX_W'(cand);
        gnt[cand]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel memory request arbiter: merges cache/master request channels onto
// one memory bus with a single outstanding transaction and a response timeout.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = CORE_ADDR_W,
  parameter int DATA_W    = CORE_DATA_W,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req_valid_i,
  input  logic [NUM_CH-1:0]        ch_wen_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata_i,
  input  logic [NUM_CH*2-1:0]      ch_wlen_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic [NUM_CH-1:0]        ch_resp_valid_o,
  output logic [NUM_CH-1:0]        ch_err_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic                     mem_wen_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [DATA_W-1:0]        mem_wdata_o,
  output logic [1:0]               mem_wlen_o,
  input  logic                     mem_resp_valid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i
);

  localparam int IDX_W = idx_width(NUM_CH);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);

  arb_state_t state_q, state_d;

  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  gnt_idx_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        wlen_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              resp_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [NUM_CH-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [IDX_W-1:0]  next_ptr;

  logic grant_fire;
  logic accept_fire;
  logic resp_fire;
  logic tmo_fire;

  rr_arbiter #(
    .NUM_CH    (NUM_CH),
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .req       (ch_req_valid_i),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign next_ptr = (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);

  // Handshakes: a channel request is consumed in the cycle its ch_ready_o bit
  // pulses; the bus request holds mem_req_valid_o and all fields stable until
  // the cycle mem_req_ready_i is seen high, and only then waits for the reply.
  always_comb begin
    state_d     = state_q;
    grant_fire  = 1'b0;
    accept_fire = 1'b0;
    resp_fire   = 1'b0;
    tmo_fire    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (arb_valid) begin
          grant_fire = 1'b1;
          state_d    = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_req_ready_i) begin
          accept_fire = 1'b1;
          state_d     = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // A response landing on the expiry cycle beats the timeout.
        if (mem_resp_valid_i) begin
          resp_fire = 1'b1;
          state_d   = ARB_IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == TMO_LAST)) begin
          tmo_fire = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wlen_q    <= 2'b00;
      cnt_q     <= '0;
      resp_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_fire | tmo_fire;
      err_q   <= tmo_fire;
      if (resp_fire) begin
        rdata_q <= mem_rdata_i;
      end else if (tmo_fire) begin
        rdata_q <= '0;
      end
      if (grant_fire) begin
        gnt_idx_q <= arb_idx;
        ptr_q     <= next_ptr;
        wen_q     <= ch_wen_i[arb_idx];
        addr_q    <= ch_addr_i[int'(arb_idx)*ADDR_W +: ADDR_W];
        wdata_q   <= ch_wdata_i[int'(arb_idx)*DATA_W +: DATA_W];
        wlen_q    <= ch_wlen_i[int'(arb_idx)*2 +: 2];
      end
      if (accept_fire) begin
        cnt_q <= '0;
      end else if (state_q == ARB_WAIT) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is held so nothing leaks mid-reset.
  assign ch_ready_o      = (!rst && (state_q == ARB_IDLE)) ? arb_gnt : '0;
  assign ch_resp_valid_o = (!rst && resp_q) ? (CH_ONE << gnt_idx_q) : '0;
  assign ch_err_o        = (!rst && err_q)  ? (CH_ONE << gnt_idx_q) : '0;
  assign ch_rdata_o      = rst ? '0 : rdata_q;
  assign mem_req_valid_o = !rst && (state_q == ARB_REQ);
  assign mem_wen_o       = !rst && wen_q;
  assign mem_addr_o      = rst ? '0 : addr_q;
  assign mem_wdata_o     = rst ? '0 : wdata_q;
  assign mem_wlen_o      = rst ? 2'b00 : wlen_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: a round-robin and a fixed-priority instance driven
// from shared inputs, checked cycle by cycle against a transaction-level model.
module tb_mem_req_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic use_fp;
  logic rst_a, rst_b;
  assign rst_a = use_fp ? 1'b1 : rst;
  assign rst_b = use_fp ? rst : 1'b1;

  logic [NCH-1:0]    req_valid, req_wen;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*2-1:0]  req_wlen;
  logic              mem_req_ready, mem_resp_valid;
  logic [DW-1:0]     mem_rdata;

  logic [NCH-1:0] a_ready, a_resp, a_err, b_ready, b_resp, b_err;
  logic [DW-1:0]  a_rdata, b_rdata, a_wdata, b_wdata;
  logic [AW-1:0]  a_addr, b_addr;
  logic           a_mval, b_mval, a_wen, b_wen;
  logic [1:0]     a_wlen, b_wlen;

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .rst(rst_a),
    .ch_req_valid_i(req_valid), .ch_wen_i(req_wen), .ch_addr_i(req_addr),
    .ch_wdata_i(req_wdata), .ch_wlen_i(req_wlen),
    .ch_ready_o(a_ready), .ch_resp_valid_o(a_resp), .ch_err_o(a_err), .ch_rdata_o(a_rdata),
    .mem_req_valid_o(a_mval), .mem_req_ready_i(mem_req_ready), .mem_wen_o(a_wen),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wdata), .mem_wlen_o(a_wlen),
    .mem_resp_valid_i(mem_resp_valid), .mem_rdata_i(mem_rdata)
  );

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(TMO)) dut_fp (
    .clk(clk), .rst(rst_b),
    .ch_req_valid_i(req_valid), .ch_wen_i(req_wen), .ch_addr_i(req_addr),
    .ch_wdata_i(req_wdata), .ch_wlen_i(req_wlen),
    .ch_ready_o(b_ready), .ch_resp_valid_o(b_resp), .ch_err_o(b_err), .ch_rdata_o(b_rdata),
    .mem_req_valid_o(b_mval), .mem_req_ready_i(mem_req_ready), .mem_wen_o(b_wen),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wdata), .mem_wlen_o(b_wlen),
    .mem_resp_valid_i(mem_resp_valid), .mem_rdata_i(mem_rdata)
  );

  logic [NCH-1:0] o_ready, o_resp, o_err;
  logic [DW-1:0]  o_rdata, o_wdata;
  logic [AW-1:0]  o_addr;
  logic           o_mval, o_wen;
  logic [1:0]     o_wlen;

  always_comb begin
    o_ready = use_fp ? b_ready : a_ready;
    o_resp  = use_fp ? b_resp  : a_resp;
    o_err   = use_fp ? b_err   : a_err;
    o_rdata = use_fp ? b_rdata : a_rdata;
    o_mval  = use_fp ? b_mval  : a_mval;
    o_wen   = use_fp ? b_wen   : a_wen;
    o_addr  = use_fp ? b_addr  : a_addr;
    o_wdata = use_fp ? b_wdata : a_wdata;
    o_wlen  = use_fp ? b_wlen  : a_wlen;
  end

  // ---------------- reference model state ----------------
  // Pending channel requests as the masters see them.
  logic          pend[NCH];
  logic          p_wen[NCH];
  logic [AW-1:0] p_addr[NCH];
  logic [DW-1:0] p_wdata[NCH];
  logic [1:0]    p_wlen[NCH];

  // Transaction in flight: 0 = none, 1 = offered to the bus, 2 = awaiting reply.
  int            m_phase, m_ptr, m_ch, rdy_left, rsp_at, wait_k;
  logic          c_wen;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic [1:0]    c_wlen;
  logic          due, due_err;
  logic [DW-1:0] due_data;

  // Stimulus controls
  logic [NCH-1:0] keep_mask;
  int             raise_pct, noise_pct, ovr_rdy, ovr_rsp;
  logic           force_resp, rdata_ovr_en;
  logic [DW-1:0]  rdata_ovr;

  // Observations
  int            cyc, n_pulse, last_pulse_cyc, last_accept_cyc;
  logic [NCH-1:0] last_resp, last_err;
  logic [DW-1:0] last_rdata;
  logic          last_mwen;
  logic [AW-1:0] last_maddr;
  logic [1:0]    last_mwlen;
  int            glog_ch[$];
  int            glog_cyc[$];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Winner among pending channels: lowest index, or smallest distance from the pointer.
  function automatic int pick();
    int best, bestd, d;
    best  = -1;
    bestd = NCH;
    for (int c = 0; c < NCH; c++) begin
      if (pend[c]) begin
        d = use_fp ? c : (c - m_ptr + NCH) % NCH;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  task automatic set_req(input int ch, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] l);
    pend[ch]    = 1'b1;
    p_wen[ch]   = w;
    p_addr[ch]  = a;
    p_wdata[ch] = d;
    p_wlen[ch]  = l;
  endtask

  task automatic clear_pend();
    for (int c = 0; c < NCH; c++) pend[c] = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic run_cycle(input logic do_rst);
    int            g, gi;
    logic [NCH-1:0] e_ready, e_resp, e_err;
    for (int c = 0; c < NCH; c++) begin
      if (!pend[c] && (keep_mask[c] || ($urandom_range(99) < raise_pct)))
        set_req(c, 1'($urandom_range(1)), $urandom, $urandom, 2'($urandom_range(3)));
      req_valid[c]             = pend[c];
      req_wen[c]               = p_wen[c];
      req_addr[c*AW +: AW]     = p_addr[c];
      req_wdata[c*DW +: DW]    = p_wdata[c];
      req_wlen[c*2 +: 2]       = p_wlen[c];
    end
    rst            = do_rst;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_rdata      = rdata_ovr_en ? rdata_ovr : DW'($urandom);
    if (m_phase == 1) begin
      mem_req_ready  = (rdy_left == 0);
      mem_resp_valid = ($urandom_range(99) < noise_pct);
    end else if (m_phase == 2) begin
      mem_resp_valid = (wait_k == rsp_at);
    end else begin
      mem_resp_valid = force_resp || ($urandom_range(99) < noise_pct);
    end

    g       = (m_phase == 0) ? pick() : -1;
    e_ready = '0;
    e_resp  = '0;
    e_err   = '0;
    if (!do_rst && g >= 0) e_ready[g] = 1'b1;
    if (!do_rst && due) begin
      e_resp[m_ch] = 1'b1;
      e_err[m_ch]  = due_err;
    end

    #2;
    chk("ready", 64'(o_ready), 64'(e_ready));
    chk("resp_valid", 64'(o_resp), 64'(e_resp));
    chk("err", 64'(o_err), 64'(e_err));
    chk("mem_valid", 64'(o_mval), 64'(!do_rst && m_phase == 1));
    if (do_rst) begin
      chk("rst_rdata", 64'(o_rdata), 64'd0);
      chk("rst_fields", {o_wen, o_wlen, o_addr}, 64'd0);
      chk("rst_wdata", 64'(o_wdata), 64'd0);
    end else begin
      if (due) chk("rdata", 64'(o_rdata), 64'(due_data));
      if (m_phase == 1) begin
        chk("mem_addr", 64'(o_addr), 64'(c_addr));
        chk("mem_wdata", 64'(o_wdata), 64'(c_wdata));
        chk("mem_ctl", {o_wen, o_wlen}, {c_wen, c_wlen});
      end
    end

    if (o_ready != '0) begin
      gi = -1;
      for (int c = 0; c < NCH; c++) if (o_ready[c]) gi = c;
      glog_ch.push_back(gi);
      glog_cyc.push_back(cyc);
    end
    if (o_resp != '0) begin
      n_pulse++;
      last_resp      = o_resp;
      last_err       = o_err;
      last_rdata     = o_rdata;
      last_pulse_cyc = cyc;
    end
    if (o_mval) begin
      last_mwen  = o_wen;
      last_maddr = o_addr;
      last_mwlen = o_wlen;
      if (mem_req_ready) last_accept_cyc = cyc;
    end

    if (do_rst) begin
      m_phase = 0;
      m_ptr   = 0;
      due     = 1'b0;
      due_err = 1'b0;
    end else begin
      due     = 1'b0;
      due_err = 1'b0;
      case (m_phase)
        0: if (g >= 0) begin
          m_ch     = g;
          c_wen    = p_wen[g];
          c_addr   = p_addr[g];
          c_wdata  = p_wdata[g];
          c_wlen   = p_wlen[g];
          pend[g]  = 1'b0;
          m_ptr    = (g + 1) % NCH;
          m_phase  = 1;
          rdy_left = (ovr_rdy >= 0) ? ovr_rdy : $urandom_range(3);
        end
        1: if (rdy_left == 0) begin
          m_phase = 2;
          wait_k  = 0;
          rsp_at  = (ovr_rsp >= 0) ? ovr_rsp : $urandom_range(TMO + 2);
        end else begin
          rdy_left--;
        end
        default: if (mem_resp_valid) begin
          due      = 1'b1;
          due_data = mem_rdata;
          m_phase  = 0;
        end else if (wait_k == TMO - 1) begin
          due      = 1'b1;
          due_err  = 1'b1;
          due_data = '0;
          m_phase  = 0;
        end else begin
          wait_k++;
        end
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- directed + random sequence ----------------
  int n0;

  initial begin
    use_fp = 1'b0; rst = 1'b1;
    keep_mask = '0; raise_pct = 0; noise_pct = 0; ovr_rdy = -1; ovr_rsp = -1;
    force_resp = 1'b0; rdata_ovr_en = 1'b0; rdata_ovr = '0;
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_wlen = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    m_phase = 0; m_ptr = 0; m_ch = 0; rdy_left = 0; rsp_at = 0; wait_k = 0;
    c_wen = 1'b0; c_addr = '0; c_wdata = '0; c_wlen = '0;
    due = 1'b0; due_err = 1'b0; due_data = '0;
    cyc = 0; n_pulse = 0; last_pulse_cyc = 0; last_accept_cyc = 0;
    last_resp = '0; last_err = '0; last_rdata = '0;
    last_mwen = 1'b0; last_maddr = '0; last_mwlen = '0;
    for (int c = 0; c < NCH; c++) set_req(c, 1'b0, '0, '0, 2'd0);
    clear_pend();

    run_cycle(1'b1);
    run_cycle(1'b1);

    // Single read on ch1: bus ready after 2 cycles, reply 3 cycles into the wait.
    set_req(1, 1'b0, 32'h8000_0010, 32'h0, 2'd0);
    ovr_rdy = 2; ovr_rsp = 3; rdata_ovr_en = 1'b1; rdata_ovr = 32'hDEAD_BEEF;
    glog_ch.delete(); glog_cyc.delete(); n0 = n_pulse;
    repeat (10) run_cycle(1'b0);
    chk("rd_grants", 64'(glog_ch.size()), 64'd1);
    chk("rd_grant_ch", 64'(glog_ch[0]), 64'd1);
    chk("rd_pulses", 64'(n_pulse - n0), 64'd1);
    chk("rd_resp_ch", 64'(last_resp), 64'b0010);
    chk("rd_err", 64'(last_err), 64'd0);
    chk("rd_data", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("rd_latency", 64'(last_pulse_cyc - glog_cyc[0]), 64'd8);

    // Write on ch0, acked one cycle into the wait.
    set_req(0, 1'b1, 32'h100, 32'h1122_3344, 2'd2);
    ovr_rdy = 0; ovr_rsp = 1; rdata_ovr_en = 1'b0; n0 = n_pulse;
    repeat (6) run_cycle(1'b0);
    chk("wr_bus_wen", 64'(last_mwen), 64'd1);
    chk("wr_bus_wlen", 64'(last_mwlen), 64'd2);
    chk("wr_bus_addr", 64'(last_maddr), 64'h100);
    chk("wr_pulses", 64'(n_pulse - n0), 64'd1);
    chk("wr_resp_ch", 64'(last_resp), 64'b0001);
    chk("wr_err", 64'(last_err), 64'd0);

    // Timeout on ch2, then a late reply two cycles after the error pulse.
    set_req(2, 1'b0, 32'h2000, 32'h0, 2'd0);
    ovr_rdy = 0; ovr_rsp = 1000; rdata_ovr_en = 1'b1; rdata_ovr = 32'h5555_AAAA;
    repeat (11) run_cycle(1'b0);
    chk("tmo_resp_ch", 64'(last_resp), 64'b0100);
    chk("tmo_err", 64'(last_err), 64'b0100);
    chk("tmo_rdata", 64'(last_rdata), 64'd0);
    chk("tmo_wait_cycles", 64'(last_pulse_cyc - last_accept_cyc), 64'd9);
    n0 = n_pulse;
    run_cycle(1'b0);
    force_resp = 1'b1;
    run_cycle(1'b0);
    force_resp = 1'b0;
    repeat (3) run_cycle(1'b0);
    chk("late_resp_dropped", 64'(n_pulse - n0), 64'd0);
    rdata_ovr_en = 1'b0;

    // Round-robin with all four channels busy and a zero-wait bus: each
    // transaction spans four cycles, the last shared with the next grant.
    run_cycle(1'b1);
    keep_mask = 4'hF; ovr_rdy = 0; ovr_rsp = 0;
    glog_ch.delete(); glog_cyc.delete();
    repeat (13) run_cycle(1'b0);
    chk("rr_grant_count", 64'(glog_ch.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog_ch.size(); i++) begin
      chk("rr_order", 64'(glog_ch[i]), 64'(i % NCH));
      if (i > 0) chk("rr_spacing", 64'(glog_cyc[i] - glog_cyc[i-1]), 64'd3);
    end

    // Fixed priority: ch0 and ch2 both keep requesting; ch2 starves.
    keep_mask = '0; clear_pend();
    use_fp = 1'b1;
    run_cycle(1'b1);
    run_cycle(1'b1);
    keep_mask = 4'b0101;
    glog_ch.delete(); glog_cyc.delete();
    repeat (15) run_cycle(1'b0);
    chk("fp_grant_count", 64'(glog_ch.size()), 64'd5);
    for (int i = 0; i < glog_ch.size(); i++) chk("fp_ch0_wins", 64'(glog_ch[i]), 64'd0);
    keep_mask = 4'b0100;
    repeat (10) run_cycle(1'b0);
    chk("fp_ch2_after_ch0_drops", 64'(glog_ch[glog_ch.size()-1]), 64'd2);

    // Reset while waiting: no stale pulse, pointer back to channel 0.
    keep_mask = '0; clear_pend();
    use_fp = 1'b0;
    run_cycle(1'b1);
    set_req(1, 1'b0, 32'h3000, 32'h0, 2'd0);
    ovr_rdy = 0; ovr_rsp = 1000;
    repeat (4) run_cycle(1'b0);
    n0 = n_pulse;
    keep_mask = 4'hF;
    run_cycle(1'b1);
    glog_ch.delete(); glog_cyc.delete();
    repeat (3) run_cycle(1'b0);
    chk("rst_wait_regrant_ch0", 64'(glog_ch[0]), 64'd0);
    chk("rst_wait_no_pulse", 64'(n_pulse - n0), 64'd0);

    // Random traffic, both arbitration modes, with bus noise and timeouts.
    keep_mask = '0; ovr_rdy = -1; ovr_rsp = -1; raise_pct = 25; noise_pct = 15;
    run_cycle(1'b1);
    repeat (1200) run_cycle(1'b0);
    use_fp = 1'b1;
    run_cycle(1'b1);
    repeat (1200) run_cycle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
